// File: rtl/ecc_pmul_sched.sv
// ecc_pmul_sched: sequences one P-256 point multiply (load, start, run, capture, done),
// measures core cycles and flags dropped start requests.
// Optional RUN-state timeout abort is built when ECC_PMUL_TIMEOUT_EN is defined.
module ecc_pmul_sched #(
  parameter int unsigned pCNT_WIDTH = 32,
  parameter int unsigned pTIMEOUT   = 2000000
) (
  input  logic                  crypto_clk,
  input  logic                  reset_i,
  input  logic                  reg_go_i,
  input  logic                  ext_trig_i,
  input  logic                  core_done_i,
  output logic                  load_o,
  output logic                  core_start_o,
  output logic                  capture_o,
  output logic                  busy_o,
  output logic                  trig_o,
  output logic                  done_o,
  output logic                  overrun_o,
  output logic                  err_timeout_o,
  output logic [pCNT_WIDTH-1:0] cycles_o
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StRun,
    StCapture,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic                    ext_q;
  // Blocks an edge on the first cycle after reset so a level held through release is ignored
  logic                    armed_q;
  logic [pCNT_WIDTH-1:0]   cycles_q, cycles_d;
  logic                    overrun_q, overrun_d;
  logic                    err_q, err_d;
  logic                    start_req;
  logic                    timeout_hit;
  logic [pCNT_WIDTH-1:0]   cycles_inc;

  assign start_req  = reg_go_i | (armed_q & ext_trig_i & ~ext_q);
  // Saturating increment
  assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + pCNT_WIDTH'(1);

`ifdef ECC_PMUL_TIMEOUT_EN
  assign timeout_hit = (cycles_q >= pCNT_WIDTH'(pTIMEOUT));
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^pCNT_WIDTH'(pTIMEOUT);
`endif

  // Next-state, cycle counter and sticky flag update
  always_comb begin
    state_d   = state_q;
    cycles_d  = cycles_q;
    overrun_d = overrun_q;
    err_d     = err_q;
    if (start_req && state_q != StIdle) begin
      overrun_d = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d   = StLoad;
          overrun_d = 1'b0;
          err_d     = 1'b0;
        end
      end
      StLoad:  state_d = StStart;
      StStart: begin
        state_d  = StRun;
        cycles_d = '0;
      end
      StRun: begin
        // Completion wins over a timeout reached in the same cycle
        if (core_done_i) begin
          state_d  = StCapture;
          cycles_d = cycles_inc;
        end else if (timeout_hit) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          cycles_d = cycles_inc;
        end
      end
      StCapture: state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // State and status registers, cleared asynchronously on reset
  always_ff @(posedge crypto_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      ext_q     <= 1'b0;
      armed_q   <= 1'b0;
      cycles_q  <= '0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ext_q     <= ext_trig_i;
      armed_q   <= 1'b1;
      cycles_q  <= cycles_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
    end
  end

  // Strobes decode straight from the state register so reset clears them immediately
  assign load_o        = (state_q == StLoad);
  assign core_start_o  = (state_q == StStart);
  assign capture_o     = (state_q == StCapture);
  assign done_o        = (state_q == StDone);
  assign busy_o        = (state_q != StIdle);
  assign trig_o        = (state_q == StStart) || (state_q == StRun);
  assign overrun_o     = overrun_q;
  assign err_timeout_o = err_q;
  assign cycles_o      = cycles_q;

endmodule

// File: tb/tb_ecc_pmul_sched.sv
// Directed bench for ecc_pmul_sched: per-cycle vector table plus hand sequences for
// latency, overrun, reset abort and timeout behaviour.
module tb_ecc_pmul_sched;

  logic        crypto_clk = 1'b0;
  logic        reset_i;
  logic        reg_go_i, ext_trig_i, core_done_i;
  logic        load_o, core_start_o, capture_o, busy_o, trig_o, done_o;
  logic        overrun_o, err_timeout_o;
  logic [31:0] cycles_o;

  int errors = 0;
  int checks = 0;

  ecc_pmul_sched #(
    .pCNT_WIDTH(32),
    .pTIMEOUT  (50)
  ) dut (
    .crypto_clk   (crypto_clk),
    .reset_i      (reset_i),
    .reg_go_i     (reg_go_i),
    .ext_trig_i   (ext_trig_i),
    .core_done_i  (core_done_i),
    .load_o       (load_o),
    .core_start_o (core_start_o),
    .capture_o    (capture_o),
    .busy_o       (busy_o),
    .trig_o       (trig_o),
    .done_o       (done_o),
    .overrun_o    (overrun_o),
    .err_timeout_o(err_timeout_o),
    .cycles_o     (cycles_o)
  );

  always #5 crypto_clk = ~crypto_clk;

  typedef struct {
    logic        go, ext, cd;
    logic        load, start, cap, busy, trig, done, ovr;
    int unsigned cyc;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int unsigned got, input int unsigned want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(negedge crypto_clk);
  endtask

  task automatic chk_strobes(input string tag, input logic l, input logic s, input logic c,
                             input logic b, input logic t, input logic d);
    check({tag, " load"},  32'(load_o),       32'(l));
    check({tag, " start"}, 32'(core_start_o), 32'(s));
    check({tag, " cap"},   32'(capture_o),    32'(c));
    check({tag, " busy"},  32'(busy_o),       32'(b));
    check({tag, " trig"},  32'(trig_o),       32'(t));
    check({tag, " done"},  32'(done_o),       32'(d));
  endtask

  initial begin
    bit saw_done, saw_cap;
    // go ext cd | load start cap busy trig done ovr | cyc
    vecs[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};  // simultaneous go + ext edge
    vecs[1]  = '{0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0};  // LOAD; core_done ignored
    vecs[2]  = '{0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0};  // START
    vecs[3]  = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0};  // RUN
    vecs[4]  = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1};
    vecs[5]  = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 2};  // core done
    vecs[6]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 3};  // CAPTURE
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 3};  // DONE
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3};  // IDLE; held ext gave no restart
    vecs[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3};  // fresh ext edge
    vecs[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 3};
    vecs[11] = '{0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 3};
    vecs[12] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0};  // counter cleared; immediate done
    vecs[13] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    reset_i = 1'b1; reg_go_i = 1'b0; ext_trig_i = 1'b0; core_done_i = 1'b0;
    repeat (2) tick();
    chk_strobes("reset", 0, 0, 0, 0, 0, 0);
    check("reset ovr", 32'(overrun_o), 0);
    check("reset err", 32'(err_timeout_o), 0);
    check("reset cyc", cycles_o, 0);
    reset_i = 1'b0;
    repeat (2) tick();

    // Per-cycle vector table
    for (int i = 0; i < 16; i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      chk_strobes(tag, vecs[i].load, vecs[i].start, vecs[i].cap, vecs[i].busy, vecs[i].trig,
                  vecs[i].done);
      check({tag, " ovr"}, 32'(overrun_o), 32'(vecs[i].ovr));
      check({tag, " cyc"}, cycles_o, vecs[i].cyc);
      reg_go_i = vecs[i].go; ext_trig_i = vecs[i].ext; core_done_i = vecs[i].cd;
      tick();
    end
    reg_go_i = 1'b0; ext_trig_i = 1'b0; core_done_i = 1'b0;
    tick();

    // Latency: go at cycle 10, core_done at 112 -> 100 counted RUN cycles
    reg_go_i = 1'b1;
    tick();
    reg_go_i = 1'b0;
    chk_strobes("lat c11", 1, 0, 0, 1, 0, 0);
    tick();
    chk_strobes("lat c12", 0, 1, 0, 1, 1, 0);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk_strobes($sformatf("lat run%0d", i), 0, 0, 0, 1, 1, 0);
      if (i == 99) core_done_i = 1'b1;
    end
    tick();
    core_done_i = 1'b0;
    chk_strobes("lat c113", 0, 0, 1, 1, 0, 0);
    tick();
    chk_strobes("lat c114", 0, 0, 0, 1, 0, 1);
    check("lat cycles", cycles_o, 100);
    tick();
    chk_strobes("lat c115", 0, 0, 0, 0, 0, 0);

    // Overrun: go during RUN is dropped and flagged; next accepted start clears it
    reg_go_i = 1'b1;
    tick();
    reg_go_i = 1'b0;
    repeat (3) tick();
    reg_go_i = 1'b1;
    tick();
    reg_go_i = 1'b0;
    check("ovr set", 32'(overrun_o), 1);
    check("ovr no load", 32'(load_o), 0);
    check("ovr still run", 32'(trig_o), 1);
    tick();
    check("ovr no load2", 32'(load_o), 0);
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    repeat (2) tick();
    check("ovr idle busy", 32'(busy_o), 0);
    check("ovr sticky", 32'(overrun_o), 1);
    reg_go_i = 1'b1;
    tick();
    reg_go_i = 1'b0;
    check("ovr restart load", 32'(load_o), 1);
    check("ovr cleared", 32'(overrun_o), 0);
    repeat (2) tick();
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    repeat (3) tick();

    // Reset mid-RUN with ext held high through release
    reg_go_i = 1'b1;
    tick();
    reg_go_i = 1'b0;
    repeat (3) tick();
    ext_trig_i = 1'b1;
    tick();
    check("rst pre trig", 32'(trig_o), 1);
    #2 reset_i = 1'b1;
    #1;
    chk_strobes("rst async", 0, 0, 0, 0, 0, 0);
    check("rst async ovr", 32'(overrun_o), 0);
    check("rst async cyc", cycles_o, 0);
    repeat (2) tick();
    reset_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_strobes($sformatf("rst post%0d", i), 0, 0, 0, 0, 0, 0);
    end
    ext_trig_i = 1'b0;
    repeat (2) tick();

`ifdef ECC_PMUL_TIMEOUT_EN
    // Timeout abort with pTIMEOUT=50 and no core_done
    saw_done = 1'b0; saw_cap = 1'b0;
    reg_go_i = 1'b1;
    tick();
    reg_go_i = 1'b0;
    for (int i = 0; i < 200 && !saw_done; i++) begin
      tick();
      if (capture_o) saw_cap = 1'b1;
      if (done_o) saw_done = 1'b1;
    end
    check("to done seen", 32'(saw_done), 1);
    check("to no capture", 32'(saw_cap), 0);
    check("to err", 32'(err_timeout_o), 1);
    check("to cycles", cycles_o, 50);
    tick();
    reg_go_i = 1'b1;
    tick();
    reg_go_i = 1'b0;
    check("to err cleared", 32'(err_timeout_o), 0);
    repeat (2) tick();
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    repeat (3) tick();
`else
    // No timeout logic: RUN outlasts pTIMEOUT and completes normally
    saw_done = 1'b0; saw_cap = 1'b0;
    reg_go_i = 1'b1;
    tick();
    reg_go_i = 1'b0;
    tick();
    for (int i = 0; i < 60; i++) begin
      tick();
      if (capture_o) saw_cap = 1'b1;
      if (done_o) saw_done = 1'b1;
    end
    check("nto no done", 32'(saw_done), 0);
    check("nto no cap", 32'(saw_cap), 0);
    check("nto still run", 32'(trig_o), 1);
    check("nto err", 32'(err_timeout_o), 0);
    check("nto cycles", cycles_o, 59);
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    check("nto cap", 32'(capture_o), 1);
    tick();
    check("nto done", 32'(done_o), 1);
    check("nto final cycles", cycles_o, 60);
    tick();
    check("nto idle", 32'(busy_o), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
